// File: rtl/row_ram_pkg.sv
// Shared types and helpers for the ping-pong input-row store.
package row_ram_pkg;

   localparam int RCC_W = 10;

   typedef struct packed {
      logic [RCC_W-1:0] ch;
      logic [RCC_W-1:0] c;
      logic [RCC_W-1:0] r;
   } rcc_t;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_e;

   localparam int ERR_SWITCH = 0;
   localparam int ERR_RANGE  = 1;
   localparam int ERR_LAST   = 2;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/row_ram_pingpong_ram.sv
// One bank: simple dual-port row RAM with a registered, enabled read.
module row_bank_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/row_ram_pingpong.sv
// Double-buffered input-row store: one bank fills while the other
// serves strided HOUT-pixel reads to the PE data-in controller.
module row_ram_pingpong
   import row_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int HOUT       = 56,
   parameter int K          = 3,
   parameter int C          = 256,
   parameter int S          = 1,
   parameter int HINT_PAD   = 58,
   parameter int ROW_WIDTH  = 10
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   input  logic [HINT_PAD*DATA_WIDTH-1:0]      wr_data,
   input  logic                                wr_last,
   input  logic [2:0][ROW_WIDTH-1:0]           R_C_Channel,
   input  logic                                row_ready,
   output logic                                row_valid,
   output logic [HOUT-1:0][DATA_WIDTH-1:0]     data_out,
   input  logic                                row_RAM_switch,
   output logic [1:0]                          bank_full,
   output logic [2:0]                          err
);

   localparam int DEPTH = C * K;
   localparam int AW    = addr_w(DEPTH);
   localparam int RW    = HINT_PAD * DATA_WIDTH;
   localparam int IW    = $clog2(HINT_PAD) + 1;

   bank_state_e state_q [2];
   bank_state_e state_d [2];

   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wa;
   logic          wr_fire;
   logic          at_end;
   logic          wr_done;
   logic          sw_ok;

   assign bank_full = {state_q[1] == FULL, state_q[0] == FULL};
   assign wr_ready  = !bank_full[wr_bank];
   assign row_valid = bank_full[rd_bank];
   assign wr_fire   = wr_valid && wr_ready;
   assign at_end    = (wa == AW'(DEPTH - 1));
   assign wr_done   = wr_fire && at_end;
   assign sw_ok     = row_RAM_switch && row_valid;

   // A write and a switch never target the same bank, so both may apply.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         if (wr_fire && wr_bank == 1'(i))
            state_d[i] = wr_done ? FULL : FILLING;
         if (sw_ok && rd_bank == 1'(i))
            state_d[i] = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q[0] <= EMPTY;
         state_q[1] <= EMPTY;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wa         <= '0;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         if (wr_fire) wa <= at_end ? '0 : wa + AW'(1);
         if (wr_done) wr_bank <= ~wr_bank;
         if (sw_ok)   rd_bank <= ~rd_bank;
      end
   end

   int            r_i;
   int            c_i;
   int            ch_i;
   logic          oor;
   logic [AW-1:0] raddr;

   assign r_i   = int'(R_C_Channel[0]);
   assign c_i   = int'(R_C_Channel[1]);
   assign ch_i  = int'(R_C_Channel[2]);
   assign oor   = (r_i >= K) || (c_i >= K) || (ch_i >= C);
   assign raddr = oor ? '0 : AW'(ch_i * K + r_i);

   logic [RW-1:0] rdata [2];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      row_bank_ram #(
         .WIDTH (RW),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_ram (
         .clk   (clk),
         .we    (wr_fire && wr_bank == 1'(b)),
         .waddr (wa),
         .wdata (wr_data),
         .re    (row_ready),
         .raddr (raddr),
         .rdata (rdata[b])
      );
   end

   logic [IW-1:0] c_q;
   logic          oor_q;
   logic          bank_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         c_q    <= '0;
         oor_q  <= 1'b0;
         bank_q <= 1'b0;
      end else if (row_ready) begin
         c_q    <= IW'(c_i);
         oor_q  <= oor;
         bank_q <= rd_bank;
      end
   end

   logic [RW-1:0]                   word;
   logic [IW-1:0]                   col [HOUT];
   logic [HOUT-1:0][DATA_WIDTH-1:0] sel;

   assign word = rdata[bank_q];

   // Column index never wraps: (HOUT-1)*S + K - 1 < HINT_PAD <= 2**IW.
   always_comb begin
      sel = '0;
      col = '{default: '0};
      for (int j = 0; j < HOUT; j++) begin
         col[j] = c_q + IW'(S * j);
         sel[j] = word[int'(col[j]) * DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_out <= '0;
      end else if (row_ready) begin
         data_out <= oor_q ? '0 : sel;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err <= '0;
      end else begin
         if (row_RAM_switch && !row_valid) err[ERR_SWITCH] <= 1'b1;
         if (row_ready && oor)             err[ERR_RANGE]  <= 1'b1;
         if (wr_fire && (wr_last != at_end)) err[ERR_LAST] <= 1'b1;
      end
   end

endmodule

// File: doc/row_ram_pingpong.md
Name: row_ram_pingpong

Overview:
- Double-buffered input-row store that feeds the PE data-in controller.
- The write side accepts padded input-feature rows from the load/DMA stream and fills one bank.
- The read side serves the other bank: for each (kernel row, kernel col, channel) triple it returns HOUT pixels in parallel.
- The consumer's row_RAM_switch releases the read bank, and the two banks swap roles.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- HOUT, 56, pixels returned per read.
- K, 3, kernel size; also the number of kernel rows stored per channel.
- C, 256, channels stored per bank.
- S, 1, stride; pixel j of a read = stored pixel col + S*j.
- HINT_PAD, 58, padded row length in pixels; must satisfy HINT_PAD >= (HOUT-1)*S+K.
- ROW_WIDTH, 10, width of each R_C_Channel field.
- DEPTH, C*K, row words per bank (derived, localparam).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write side can accept a beat.
- wr_data  in  HINT_PAD*DATA_WIDTH  one padded row; pixel 0 in the LSBs.
- wr_last  in  1  marks the final beat of a bank fill; used for the consistency check only.
- R_C_Channel  in  3 x ROW_WIDTH  [0] = kernel row r, [1] = kernel col c, [2] = channel ch.
- row_ready  in  1  read-pipeline clock enable from the consumer.
- row_valid  out  1  read bank is full and readable.
- data_out  out  HOUT x DATA_WIDTH  selected pixels; element j = pixel (c + S*j) of stored row (ch, r).
- row_RAM_switch  in  1  one-cycle pulse: release the read bank.
- bank_full  out  2  per-bank full flags.
- err  out  3  sticky: [0] switch while not row_valid, [1] address out of range, [2] wr_last mismatch.

Behaviour:
- Reset (asynchronous, rstn low) sets:
  - both banks empty;
  - wr_bank = 0, rd_bank = 0;
  - write address = 0;
  - wr_ready = 1, row_valid = 0;
  - data_out = 0, err = 0.
  - RAM contents are not cleared. A reset mid-fill discards the partial bank.
- Write side:
  - A beat is accepted when wr_valid && wr_ready. It is stored at address wa = ch*K + r, filled in arrival order 0..DEPTH-1.
  - On the beat with wa = DEPTH-1:
    - bank_full[wr_bank] is set next cycle;
    - wa wraps to 0;
    - wr_bank toggles.
  - If wr_last differs from (wa == DEPTH-1) on an accepted beat, err[2] is set. The address counter alone decides completion.
  - wr_ready = !bank_full[wr_bank], so the write side stalls while both banks are full.
- Read side:
  - row_valid = bank_full[rd_bank].
  - Pipeline is 2 stages, both enabled by row_ready:
    - stage 1 registers the RAM word at ch*K + r of rd_bank, plus c;
    - stage 2 registers the shifted and strided selection into data_out.
  - Latency: data_out reflects the R_C_Channel value presented 2 enabled cycles earlier.
  - With row_ready low, both stages hold their values.
  - Reads are permitted when row_valid = 0; data_out is then undefined, and no error is raised.
- Out-of-range read (r >= K, c >= K, or ch >= C): that read's data_out is all zero and err[1] is set.
- row_RAM_switch:
  - If row_valid: clear bank_full[rd_bank] and toggle rd_bank, both next cycle.
  - Otherwise: ignore the pulse and set err[0].
- Simultaneous completion of a write into bank X and a switch releasing bank Y (X != Y): both take effect in the same edge.
- Bank-state machine, tracked per bank: EMPTY -> FILLING (first beat) -> FULL (last beat) -> EMPTY (switch).
  - The write and read pointers can never point at the same FILLING bank.
- Arithmetic:
  - addresses are unsigned, clog2(DEPTH) bits;
  - the column index c + S*j is computed at clog2(HINT_PAD)+1 bits, with no wrap.

Decomposition:
- Package row_ram_pkg:
  - rcc_t (three ROW_WIDTH fields), bank_state_e {EMPTY, FILLING, FULL};
  - err bit index constants;
  - a function computing the address width.
- Sub-module row_bank_ram:
  - simple dual-port, DEPTH x (HINT_PAD*DATA_WIDTH);
  - 1-cycle registered read with read enable;
  - instantiated twice, one per bank.

Test Plan:
- Fill bank 0 with a pattern: pixel p of row (ch, r) = (ch + 3r + p) mod 256; C=2, K=3 via parameters. Then:
  - bank_full = 01 one cycle after the 6th beat;
  - row_valid = 1;
  - wr_bank = 1.
- Read at RCC (1, 2, 1) with row_ready = 1: two cycles later data_out[j] = (1 + 3 + 2 + j) mod 256 for all j.
- Fill both banks with wr_valid held high: wr_ready drops after the 12th beat. Pulse row_RAM_switch:
  - bank 0 is freed and rd_bank = 1;
  - wr_ready rises the next cycle.
- Pulse row_RAM_switch with both banks empty: err = 001; the bank flags are unchanged.
- Read at RCC (3, 0, 0): data_out = 0 two cycles later and err[1] = 1. Hold row_ready low for 5 cycles mid-stream: data_out is stable throughout.
- Assert rstn low after 3 of 6 beats, then refill all 6: bank_full = 01 only after the 6th new beat; no err bits are set.
